// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID instruction queue
interface if_id_queue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  enq_valid;
    logic                  enq_ready;
    logic [DATA_WIDTH-1:0] enq_instr;
    logic [DATA_WIDTH-1:0] enq_pc;
    logic [DATA_WIDTH-1:0] enq_pcplus4;
    logic                  deq_valid;
    logic                  deq_ready;
    logic [DATA_WIDTH-1:0] deq_instr;
    logic [DATA_WIDTH-1:0] deq_pc;
    logic [DATA_WIDTH-1:0] deq_pcplus4;

    modport master (
        output enq_valid, enq_instr, enq_pc, enq_pcplus4, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc, deq_pcplus4
    );

    modport slave (
        input  enq_valid, enq_instr, enq_pc, enq_pcplus4, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc, deq_pcplus4
    );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular instruction queue between fetch and decode with flush and NOP bubble
module if_id_queue #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    if_id_queue_if.slave       q,
    output logic [PTR_WIDTH:0] count
);
    localparam logic [PTR_WIDTH:0]    FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] instr_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem      [DEPTH];
    logic [DATA_WIDTH-1:0] pcplus4_mem [DEPTH];

    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // enq_ready is purely state-derived so deq_ready never reaches it combinationally
    assign q.enq_ready = !full;
    assign q.deq_valid = !empty;
    assign push        = q.enq_valid && !full;
    assign pop         = !empty && q.deq_ready;

    assign q.deq_instr   = empty ? NOP_INSTR : instr_mem[rd_ptr];
    assign q.deq_pc      = empty ? '0        : pc_mem[rd_ptr];
    assign q.deq_pcplus4 = empty ? '0        : pcplus4_mem[rd_ptr];

    // Storage carries no reset; stale entries are masked by empty
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem[wr_ptr]   <= q.enq_instr;
            pc_mem[wr_ptr]      <= q.enq_pc;
            pcplus4_mem[wr_ptr] <= q.enq_pcplus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_WIDTH+1)'(1);
                2'b01:   count <= count - (PTR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= FULL_COUNT);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) full |-> !push);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) empty |-> !pop);
endmodule
